// File: rtl/serial_receiver_4bit.sv
// Serial-to-parallel frame receiver.
// A start request in IDLE opens a frame. The next WIDTH edges shift serialInput
// in MSB first. The completed word is then published on out, and valid pulses
// for the single DONE cycle. Back-to-back frames can start directly from DONE.
module serial_receiver_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             serialInput,
    input  logic             enableCapture,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] notout,
    output logic             valid,
    output logic             busy,
    output logic [2:0]       bitCount
);

    // Count value on the edge that samples the final bit of a frame.
    localparam logic [2:0] LAST_BIT = 3'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic [2:0]       cnt_q,   cnt_d;
    logic [WIDTH-1:0] shifted;

    // Shift register contents once the current serial bit is appended.
    assign shifted = {shift_q[WIDTH-2:0], serialInput};

    // State and datapath registers.
    // clear discards any partial frame and the last published word.
    always_ff @(posedge clockpulse or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            shift_q <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    // serialInput is consumed only in SHIFT, so out changes only on the final bit.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (enableCapture) begin
                    state_d = SHIFT;
                    shift_d = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // enableCapture is ignored here; a frame always runs WIDTH bits.
                shift_d = shifted;
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == LAST_BIT) begin
                    out_d   = shifted;
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d = '0;
                if (enableCapture) begin
                    state_d = SHIFT;
                    shift_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign out      = out_q;
    assign notout   = ~out_q;
    assign valid    = (state_q == DONE);
    assign busy     = (state_q == SHIFT);
    assign bitCount = cnt_q;

endmodule

// File: tb/tb_serial_receiver_4bit.sv
// Scoreboard bench for serial_receiver_4bit.
// The driver pushes the word each frame should produce. A monitor pops and
// compares the queue on every valid pulse.
module tb_serial_receiver_4bit;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       en = 1'b0;
    logic       si_drv = 1'b0;
    logic       loop_mode = 1'b0;
    logic       lsr_preset = 1'b0;
    logic [3:0] lsr = 4'b0000;
    logic       serialInput;
    logic [3:0] out, notout;
    logic       valid, busy;
    logic [2:0] bitCount;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q[$];
    logic       prev_valid = 1'b0;

    always #5 clk = ~clk;

    // Loopback source: a left shift register with preset, shifting in 0.
    always @(posedge clk) begin
        if (lsr_preset) lsr <= 4'b1100;
        else            lsr <= {lsr[2:0], 1'b0};
    end

    assign serialInput = loop_mode ? lsr[3] : si_drv;

    serial_receiver_4bit #(.WIDTH(4)) dut (
        .clockpulse   (clk),
        .clear        (clear),
        .serialInput  (serialInput),
        .enableCapture(en),
        .out          (out),
        .notout       (notout),
        .valid        (valid),
        .busy         (busy),
        .bitCount     (bitCount)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected word.
    always @(negedge clk) begin
        if (!clear && valid) begin
            chk("valid_single_cycle", {7'd0, prev_valid}, 8'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got out=%b expected no word", out);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                chk("sb_out", {4'd0, out}, {4'd0, e});
                chk("sb_notout", {4'd0, notout}, {4'd0, ~e});
            end
        end
        prev_valid = valid;
    end

    // Start a frame on the next edge, then feed four bits MSB first.
    // The frame ends with the DUT in DONE, visible at the final negedge.
    task automatic send_frame(input logic [3:0] bits, input bit hold_en, input bit loop);
        exp_q.push_back(loop ? 4'b1100 : bits);
        en = 1'b1;
        if (loop) begin
            loop_mode  = 1'b1;
            lsr_preset = 1'b1;
        end
        @(negedge clk);
        lsr_preset = 1'b0;
        chk("start_busy", {7'd0, busy}, 8'd1);
        chk("start_count", {5'd0, bitCount}, 8'd0);
        for (int i = 3; i >= 0; i--) begin
            en     = hold_en;
            si_drv = bits[i];
            @(negedge clk);
            if (i > 0) begin
                chk("shift_busy", {7'd0, busy}, 8'd1);
                chk("shift_count", {5'd0, bitCount}, 8'(4 - i));
                chk("shift_novalid", {7'd0, valid}, 8'd0);
            end else begin
                chk("done_busy", {7'd0, busy}, 8'd0);
                chk("done_valid", {7'd0, valid}, 8'd1);
                chk("done_count", {5'd0, bitCount}, 8'd4);
            end
        end
        loop_mode = 1'b0;
    endtask

    task automatic go_idle();
        en = 1'b0;
        @(negedge clk);
        chk("idle_valid", {7'd0, valid}, 8'd0);
        chk("idle_count", {5'd0, bitCount}, 8'd0);
    endtask

    initial begin
        // Asynchronous reset while the clock toggles.
        #1 clear = 1'b1;
        #2;
        chk("rst_out", {4'd0, out}, 8'h00);
        chk("rst_notout", {4'd0, notout}, 8'h0F);
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_count", {5'd0, bitCount}, 8'd0);
        #8 clear = 1'b0;
        @(negedge clk);

        // serialInput activity while idle must not affect anything.
        for (int k = 0; k < 3; k++) begin
            si_drv = k[0];
            @(negedge clk);
        end
        chk("idle_si_out", {4'd0, out}, 8'h00);
        chk("idle_si_busy", {7'd0, busy}, 8'd0);

        // Single frame.
        send_frame(4'b1100, 1'b0, 1'b0);
        chk("frame1_notout", {4'd0, notout}, 8'h03);

        // Back-to-back frame started from DONE.
        send_frame(4'b1010, 1'b0, 1'b0);
        go_idle();

        // enableCapture held high throughout the frame.
        send_frame(4'b0110, 1'b1, 1'b0);
        go_idle();
        chk("hold_out", {4'd0, out}, 8'h06);

        // Reset in the middle of a frame.
        send_frame(4'b1100, 1'b0, 1'b0);
        go_idle();
        en = 1'b1;
        @(negedge clk);
        en     = 1'b0;
        si_drv = 1'b1;
        @(negedge clk);
        si_drv = 1'b0;
        @(negedge clk);
        chk("mid_count_before", {5'd0, bitCount}, 8'd2);
        #2 clear = 1'b1;
        #1;
        chk("mid_out", {4'd0, out}, 8'h00);
        chk("mid_notout", {4'd0, notout}, 8'h0F);
        chk("mid_busy", {7'd0, busy}, 8'd0);
        chk("mid_count", {5'd0, bitCount}, 8'd0);
        chk("mid_valid", {7'd0, valid}, 8'd0);
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("clr_ignores_edges", {7'd0, busy}, 8'd0);
        clear = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_clr_idle", {7'd0, busy}, 8'd0);
        chk("post_clr_out", {4'd0, out}, 8'h00);

        // Loopback from a preset left shift register.
        send_frame(4'b0000, 1'b0, 1'b1);
        go_idle();
        chk("loop_out", {4'd0, out}, 8'h0C);

        repeat (3) @(negedge clk);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_receiver_4bit.md
SERIAL_RECEIVER_4BIT -- requirements
Module: serial_receiver_4bit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning number of data bits per frame; only 4 is required to be supported.
REQ-002 SHALL have port clockpulse  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port clear  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port serialInput  input  1  serial data, MSB first, matching the shift-out order of the left shift register.
REQ-005 SHALL have port enableCapture  input  1  frame start request, sampled on rising edge.
REQ-006 SHALL have port out  output  4  last completely received word, registered.
REQ-007 SHALL have port notout  output  4  bitwise complement of out.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking a new word on out.
REQ-009 SHALL have port busy  output  1  high while a frame is being shifted in.
REQ-010 SHALL have port bitCount  output  3  number of bits sampled in the current frame, 0..4.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE, all registered.
REQ-012 IDLE: enableCapture=1 at an edge -> SHIFT, internal shift register <= 0, bitCount <= 0; otherwise remain IDLE.
REQ-013 The start edge SHALL NOT sample serialInput; the first data bit is sampled on the next edge.
REQ-014 SHIFT: each edge, shift register <= {shift[2:0], serialInput}, bitCount <= bitCount+1.
REQ-015 SHIFT with bitCount=3: out <= {shift[2:0], serialInput}, bitCount <= 4, state -> DONE.
REQ-016 Latency: start at edge N; bits sampled at N+1..N+4; out updated at N+4.
REQ-017 valid SHALL be 1 exactly while in DONE, i.e. one cycle, N+4 to N+5.
REQ-018 busy SHALL be 1 exactly while in SHIFT.
REQ-019 DONE: enableCapture=1 -> SHIFT with bitCount <= 0 (back-to-back frames, no idle cycle); else -> IDLE with bitCount <= 0.
REQ-020 enableCapture during SHIFT SHALL be ignored; the frame in progress completes unchanged.
REQ-021 out SHALL hold its value except at the REQ-015 update; partial frames never reach out.
REQ-022 notout SHALL equal ~out at all times, combinationally.
REQ-023 serialInput values outside SHIFT SHALL have no effect on any output.

Reset
REQ-024 clear=1 SHALL immediately force state IDLE, shift register 0, bitCount 0, out 4'b0000, notout 4'b1111, valid 0, busy 0, independent of clockpulse.
REQ-025 While clear=1, all rising edges SHALL be ignored, including enableCapture.
REQ-026 clear asserted mid-frame SHALL discard the partial frame; out SHALL read 0, not the prior word.
REQ-027 After clear deasserts, the first action SHALL require a fresh enableCapture in IDLE.

Verification
REQ-028 Reset: clear=1 for 10 time units with clock toggling -> out=0000, notout=1111, valid=0, busy=0, bitCount=0.
REQ-029 Single frame: enableCapture=1 for one edge, then serialInput 1,1,0,0 on the next 4 edges -> busy high 4 cycles; out=1100, notout=0011 after 4th bit; valid high for exactly one cycle.
REQ-030 Back-to-back: enableCapture=1 during DONE, then bits 1,0,1,0 -> out=1010 exactly 4 edges after the DONE edge; no IDLE cycle between valid pulses.
REQ-031 Ignored start: enableCapture held 1 throughout a frame of bits 0,1,1,0 -> out=0110; frame length unchanged at 4 bits.
REQ-032 Reset mid-operation: out=1100 held, then start a new frame, assert clear after 2 bits -> out=0000 immediately, busy=0, bitCount=0; no valid pulse.
REQ-033 Loopback: left shift register (clear, preset 1100 with enablePreset, serialInput 0) feeding its out[3] to serialInput, enableCapture issued on the preset edge -> out=1100 with valid one cycle.
